// File: rtl/approx_mult_pkg.sv
// Shared helpers for the approximate multiplier pipeline: adder cells,
// partial-product row masks and saturating statistics arithmetic.
package approx_mult_pkg;

   localparam int STAT_W = 32;
   localparam int MAX_W  = 16;

   // Returns {carry, sum}.
   function automatic logic [1:0] exact_fa(input logic x, input logic y, input logic z);
      return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
   endfunction

   // Returns {carry, sum}. Errs only for (x,y,z) = 011 (+1) and 101 (-1).
   function automatic logic [1:0] approx_fa(input logic x, input logic y, input logic z);
      return {y & (x | z), (x | y | z) & ~(x & y & ~z)};
   endfunction

   // odd = 0 selects bits 0,2,4,...; odd = 1 selects bits 1,3,5,...
   function automatic logic [MAX_W-1:0] row_mask(input logic odd);
      logic [MAX_W-1:0] m;
      for (int i = 0; i < MAX_W; i++) begin
         m[i] = (i[0] == odd);
      end
      return m;
   endfunction

   function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                 input logic [STAT_W:0]   b);
      logic [STAT_W+1:0] s;
      s = {2'b00, a} + {1'b0, b};
      if (|s[STAT_W+1:STAT_W]) begin
         return '1;
      end
      return s[STAT_W-1:0];
   endfunction

endpackage

// File: rtl/approx_mult_rc_adder.sv
// Ripple-carry final adder; the low APPROX_COLS positions switch to the
// approximate cell when approx is set. Carry out of the top bit is dropped.
module approx_rc_adder
   import approx_mult_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int APPROX_COLS = 2
) (
   input  logic [2*WIDTH-1:0] x,
   input  logic [2*WIDTH-1:0] y,
   input  logic               approx,
   output logic [2*WIDTH-1:0] sum
);

   always_comb begin
      logic       c;
      logic [1:0] r;
      c   = 1'b0;
      r   = 2'b00;
      sum = '0;
      for (int i = 0; i < 2*WIDTH; i++) begin
         if (approx && (i < APPROX_COLS)) begin
            r = approx_fa(x[i], y[i], c);
         end else begin
            r = exact_fa(x[i], y[i], c);
         end
         sum[i] = r[0];
         c      = r[1];
      end
   end

endmodule

// File: rtl/approx_mult_pipe.sv
// Three-stage valid/ready approximate multiplier with per-transaction mode,
// signed error output and saturating on-line error statistics.
module approx_mult_pipe
   import approx_mult_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int APPROX_COLS = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_a,
   input  logic [WIDTH-1:0]          in_b,
   input  logic                      in_approx,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2*WIDTH-1:0]        out_p,
   output logic signed [2*WIDTH:0]   out_err,
   output logic                      out_approx,
   input  logic                      stats_clr,
   output logic [STAT_W-1:0]         stat_cnt,
   output logic [STAT_W-1:0]         stat_err_sum
);

   localparam int PW = 2*WIDTH;
   localparam int EW = PW + 1;

   localparam logic [MAX_W-1:0] EVEN_FULL = row_mask(1'b0);
   localparam logic [MAX_W-1:0] ODD_FULL  = row_mask(1'b1);
   localparam logic [WIDTH-1:0] EVEN_M    = EVEN_FULL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ODD_M     = ODD_FULL[WIDTH-1:0];

   // Handshake: a transfer happens on a rising edge where valid & ready are
   // both high; stage k moves forward when stage k+1 is empty or moving.
   logic             s1_valid, s1_approx;
   logic [WIDTH-1:0] s1_a, s1_b;
   logic             s2_valid, s2_approx;
   logic [PW-1:0]    s2_x, s2_y, s2_exact;

   logic             s3_free, s2_free, s1_adv, s2_adv, hs;
   logic [PW-1:0]    a_ext, row_x, row_y, exact_p, sum;
   logic [EW-1:0]    err_next, abs_err;
   logic [STAT_W:0]  abs_ext;

   assign s3_free  = !out_valid || out_ready;
   assign s2_free  = !s2_valid || s3_free;
   assign s1_adv   = s1_valid && s2_free;
   assign s2_adv   = s2_valid && s3_free;
   assign in_ready = !s1_valid || s2_free;
   assign hs       = out_valid && out_ready;

   assign a_ext   = {{WIDTH{1'b0}}, s1_a};
   assign row_x   = a_ext * {{WIDTH{1'b0}}, s1_b & EVEN_M};
   assign row_y   = a_ext * {{WIDTH{1'b0}}, s1_b & ODD_M};
   assign exact_p = a_ext * {{WIDTH{1'b0}}, s1_b};

   approx_rc_adder #(
      .WIDTH       (WIDTH),
      .APPROX_COLS (APPROX_COLS)
   ) u_adder (
      .x      (s2_x),
      .y      (s2_y),
      .approx (s2_approx),
      .sum    (sum)
   );

   // Modular subtraction in EW bits yields the two's-complement error directly.
   assign err_next = {1'b0, sum} - {1'b0, s2_exact};
   assign abs_err  = out_err[EW-1] ? EW'(-out_err) : EW'(out_err);
   assign abs_ext  = (STAT_W+1)'(abs_err);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_a       <= '0;
         s1_b       <= '0;
         s1_approx  <= 1'b0;
         s2_valid   <= 1'b0;
         s2_x       <= '0;
         s2_y       <= '0;
         s2_exact   <= '0;
         s2_approx  <= 1'b0;
         out_valid  <= 1'b0;
         out_p      <= '0;
         out_err    <= '0;
         out_approx <= 1'b0;
      end else begin
         if (in_ready) begin
            s1_valid <= in_valid;
         end
         if (in_valid && in_ready) begin
            s1_a      <= in_a;
            s1_b      <= in_b;
            s1_approx <= in_approx;
         end
         if (s2_free) begin
            s2_valid <= s1_valid;
         end
         if (s1_adv) begin
            s2_x      <= row_x;
            s2_y      <= row_y;
            s2_exact  <= exact_p;
            s2_approx <= s1_approx;
         end
         if (s3_free) begin
            out_valid <= s2_valid;
         end
         if (s2_adv) begin
            out_p      <= sum;
            out_err    <= err_next;
            out_approx <= s2_approx;
         end
      end
   end

   // Clear wins over accumulation but still records the coincident handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_cnt     <= '0;
         stat_err_sum <= '0;
      end else if (stats_clr) begin
         stat_cnt     <= hs ? STAT_W'(1) : '0;
         stat_err_sum <= hs ? sat_add('0, abs_ext) : '0;
      end else if (hs) begin
         stat_cnt     <= sat_add(stat_cnt, (STAT_W+1)'(1));
         stat_err_sum <= sat_add(stat_err_sum, abs_ext);
      end
   end

endmodule
